vp_spec_controller: RTL and testbench



---
 rtl/vp_spec_controller.sv | 277 +++++++++++++++++++++++++++
 tb/tb_vp_spec_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_spec_controller.sv
// ============================================================================
// vp_spec_controller
// ----------------------------------------------------------------------------
// Load-value speculation sequencer.
//
// On a MEM-stage load that hits in the D-cache in the issuing cycle, the
// returned value simply trains the value predictor. On a miss it snapshots
// the register state and looks up a predicted value. If the predictor is
// confident, that value is forwarded into the pipeline while the real data
// is awaited. A correct prediction trains the predictor and retires the
// speculation. A wrong prediction, or a timeout, restores the snapshot and
// then flushes the pipeline. Only one speculation is outstanding at a time.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ld_req_valid/addr MEM-stage load request towards the D-cache
//   dc_valid/data     D-cache load data return
//   pred_valid/data   predictor response, valid one cycle after vp_en
//   snap_done         snapshot capture complete
//   recover_done      snapshot restore complete
//   vp_en             one-cycle predictor lookup strobe
//   vp_addr           latched load address (lookup and training)
//   vp_update(_data)  one-cycle training strobe and the actual loaded value
//   snap_take         one-cycle snapshot capture strobe
//   recover_snapshot  held high until recover_done
//   spec_value(_valid) predicted value forwarded to the pipeline
//   ov_stall/ov_flush pipeline override controls
//   spec_active       controller is not idle
//   n_correct/n_wrong saturating prediction statistics
// ============================================================================
module vp_spec_controller #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_SPEC_CYCLES = 64,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req_valid,
    input  logic [ADDR_WIDTH-1:0] ld_req_addr,
    input  logic                  dc_valid,
    input  logic [DATA_WIDTH-1:0] dc_data,
    input  logic                  pred_valid,
    input  logic [DATA_WIDTH-1:0] pred_data,
    input  logic                  snap_done,
    input  logic                  recover_done,
    output logic                  vp_en,
    output logic [ADDR_WIDTH-1:0] vp_addr,
    output logic                  vp_update,
    output logic [DATA_WIDTH-1:0] vp_update_data,
    output logic                  snap_take,
    output logic                  recover_snapshot,
    output logic                  spec_value_valid,
    output logic [DATA_WIDTH-1:0] spec_value,
    output logic                  ov_stall,
    output logic                  ov_flush,
    output logic                  spec_active,
    output logic [CNT_WIDTH-1:0]  n_correct,
    output logic [CNT_WIDTH-1:0]  n_wrong
);

    localparam int SPEC_CNT_W = (MAX_SPEC_CYCLES > 2) ? $clog2(MAX_SPEC_CYCLES) : 1;
    localparam logic [SPEC_CNT_W-1:0] SPEC_LAST = SPEC_CNT_W'(MAX_SPEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_SPEC,
        S_NOSPEC,
        S_RECOVER,
        S_FLUSH
    } state_t;

    // Position inside SNAP: first cycle carries the strobes, second cycle
    // carries the predictor response, anything later just waits for snap_done.
    localparam logic [1:0] SNAP_FIRST  = 2'd0;
    localparam logic [1:0] SNAP_SECOND = 2'd1;
    localparam logic [1:0] SNAP_LATER  = 2'd2;

    state_t                  state_q,          state_d;
    logic [1:0]              snap_cyc_q,       snap_cyc_d;
    logic                    snap_done_seen_q, snap_done_seen_d;
    logic                    pred_hit_q,       pred_hit_d;
    logic [DATA_WIDTH-1:0]   pred_reg_q,       pred_reg_d;
    logic                    act_seen_q,       act_seen_d;
    logic [DATA_WIDTH-1:0]   act_reg_q,        act_reg_d;
    logic [SPEC_CNT_W-1:0]   spec_cnt_q,       spec_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,           addr_d;
    logic                    vp_update_q,      vp_update_d;
    logic [DATA_WIDTH-1:0]   vp_update_data_q, vp_update_data_d;
    logic [CNT_WIDTH-1:0]    n_correct_q,      n_correct_d;
    logic [CNT_WIDTH-1:0]    n_wrong_q,        n_wrong_d;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and latch update logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        snap_cyc_d       = snap_cyc_q;
        snap_done_seen_d = snap_done_seen_q;
        pred_hit_d       = pred_hit_q;
        pred_reg_d       = pred_reg_q;
        act_seen_d       = act_seen_q;
        act_reg_d        = act_reg_q;
        spec_cnt_d       = spec_cnt_q;
        addr_d           = addr_q;
        vp_update_d      = 1'b0;
        vp_update_data_d = vp_update_data_q;
        n_correct_d      = n_correct_q;
        n_wrong_d        = n_wrong_q;

        case (state_q)
            S_IDLE: begin
                if (ld_req_valid) begin
                    addr_d = ld_req_addr;
                    if (dc_valid) begin
                        // Same-cycle hit: nothing to speculate, just train.
                        vp_update_d      = 1'b1;
                        vp_update_data_d = dc_data;
                    end else begin
                        state_d          = S_SNAP;
                        snap_cyc_d       = SNAP_FIRST;
                        snap_done_seen_d = 1'b0;
                        pred_hit_d       = 1'b0;
                        act_seen_d       = 1'b0;
                    end
                end
            end

            S_SNAP: begin
                if (snap_cyc_q != SNAP_LATER) begin
                    snap_cyc_d = snap_cyc_q + 2'd1;
                end
                // The predictor answers exactly one cycle after vp_en.
                if (snap_cyc_q == SNAP_SECOND) begin
                    pred_hit_d = pred_valid;
                    pred_reg_d = pred_data;
                end
                // The real data may overtake the snapshot; keep it so the
                // speculation can be skipped altogether.
                if (dc_valid) begin
                    act_seen_d = 1'b1;
                    act_reg_d  = dc_data;
                end
                if (snap_done) begin
                    snap_done_seen_d = 1'b1;
                end
                // An early snap_done is remembered but never honoured before
                // the predictor response has been captured.
                if ((snap_cyc_q != SNAP_FIRST) && (snap_done || snap_done_seen_q)) begin
                    if (act_seen_d) begin
                        state_d          = S_IDLE;
                        vp_update_d      = 1'b1;
                        vp_update_data_d = act_reg_d;
                    end else if (pred_hit_d) begin
                        state_d    = S_SPEC;
                        spec_cnt_d = '0;
                    end else begin
                        state_d = S_NOSPEC;
                    end
                end
            end

            S_NOSPEC: begin
                if (dc_valid) begin
                    state_d          = S_IDLE;
                    vp_update_d      = 1'b1;
                    vp_update_data_d = dc_data;
                end
            end

            S_SPEC: begin
                // Data return takes priority over a timeout in the same cycle.
                if (dc_valid) begin
                    vp_update_d      = 1'b1;
                    vp_update_data_d = dc_data;
                    if (dc_data == pred_reg_q) begin
                        n_correct_d = sat_inc(n_correct_q);
                        state_d     = S_IDLE;
                    end else begin
                        n_wrong_d = sat_inc(n_wrong_q);
                        state_d   = S_RECOVER;
                    end
                end else if (spec_cnt_q == SPEC_LAST) begin
                    n_wrong_d = sat_inc(n_wrong_q);
                    state_d   = S_RECOVER;
                end else begin
                    spec_cnt_d = spec_cnt_q + SPEC_CNT_W'(1);
                end
            end

            S_RECOVER: begin
                if (recover_done) begin
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and latch registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            snap_cyc_q       <= SNAP_FIRST;
            snap_done_seen_q <= 1'b0;
            pred_hit_q       <= 1'b0;
            pred_reg_q       <= '0;
            act_seen_q       <= 1'b0;
            act_reg_q        <= '0;
            spec_cnt_q       <= '0;
            addr_q           <= '0;
            vp_update_q      <= 1'b0;
            vp_update_data_q <= '0;
            n_correct_q      <= '0;
            n_wrong_q        <= '0;
        end else begin
            state_q          <= state_d;
            snap_cyc_q       <= snap_cyc_d;
            snap_done_seen_q <= snap_done_seen_d;
            pred_hit_q       <= pred_hit_d;
            pred_reg_q       <= pred_reg_d;
            act_seen_q       <= act_seen_d;
            act_reg_q        <= act_reg_d;
            spec_cnt_q       <= spec_cnt_d;
            addr_q           <= addr_d;
            vp_update_q      <= vp_update_d;
            vp_update_data_q <= vp_update_data_d;
            n_correct_q      <= n_correct_d;
            n_wrong_q        <= n_wrong_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // Strobes come from the first SNAP cycle only. Overrides and the recovery
    // request are masked by rst directly so they drop in the reset cycle
    // itself rather than one edge later. The SPEC-state stall is the one
    // combinational path from an input: it blocks a second load immediately.
    always_comb begin
        snap_take        = (state_q == S_SNAP) && (snap_cyc_q == SNAP_FIRST);
        vp_en            = (state_q == S_SNAP) && (snap_cyc_q == SNAP_FIRST);
        vp_addr          = addr_q;
        vp_update        = vp_update_q;
        vp_update_data   = vp_update_data_q;
        spec_value_valid = (state_q == S_SPEC);
        spec_value       = (state_q == S_SPEC) ? pred_reg_q : '0;
        recover_snapshot = !rst && (state_q == S_RECOVER);
        ov_flush         = !rst && (state_q == S_FLUSH);
        ov_stall         = !rst && ((state_q == S_SNAP)    ||
                                    (state_q == S_RECOVER) ||
                                    (state_q == S_FLUSH)   ||
                                    ((state_q == S_SPEC) && ld_req_valid));
        spec_active      = (state_q != S_IDLE);
        n_correct        = n_correct_q;
        n_wrong          = n_wrong_q;
    end

endmodule

// File: tb/tb_vp_spec_controller.sv
module tb_vp_spec_controller;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MSC = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req_valid;
    logic [AW-1:0] ld_req_addr;
    logic          dc_valid;
    logic [DW-1:0] dc_data;
    logic          pred_valid;
    logic [DW-1:0] pred_data;
    logic          snap_done;
    logic          recover_done;
    logic          vp_en;
    logic [AW-1:0] vp_addr;
    logic          vp_update;
    logic [DW-1:0] vp_update_data;
    logic          snap_take;
    logic          recover_snapshot;
    logic          spec_value_valid;
    logic [DW-1:0] spec_value;
    logic          ov_stall;
    logic          ov_flush;
    logic          spec_active;
    logic [CW-1:0] n_correct;
    logic [CW-1:0] n_wrong;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } upd_t;

    upd_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    vp_spec_controller #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MAX_SPEC_CYCLES(MSC),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_req_valid    (ld_req_valid),
        .ld_req_addr     (ld_req_addr),
        .dc_valid        (dc_valid),
        .dc_data         (dc_data),
        .pred_valid      (pred_valid),
        .pred_data       (pred_data),
        .snap_done       (snap_done),
        .recover_done    (recover_done),
        .vp_en           (vp_en),
        .vp_addr         (vp_addr),
        .vp_update       (vp_update),
        .vp_update_data  (vp_update_data),
        .snap_take       (snap_take),
        .recover_snapshot(recover_snapshot),
        .spec_value_valid(spec_value_valid),
        .spec_value      (spec_value),
        .ov_stall        (ov_stall),
        .ov_flush        (ov_flush),
        .spec_active     (spec_active),
        .n_correct       (n_correct),
        .n_wrong         (n_wrong)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 ns after the edge; any training pulse
    // must match the oldest expected update in the scoreboard.
    task automatic tick();
        upd_t e;
        @(posedge clk);
        #1;
        if (vp_update === 1'b1) begin
            chk("sb_pending", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("vp_update_data", 64'(vp_update_data), 64'(e.data));
                chk("vp_addr_upd", 64'(vp_addr), 64'(e.addr));
            end
        end
    endtask

    // Miss in IDLE, SNAP with snap_done in its second cycle; returns in the
    // first cycle of SPEC/NOSPEC.
    task automatic start_spec(input logic [AW-1:0] a, input logic pv, input logic [DW-1:0] pd);
        ld_req_valid = 1'b1;
        ld_req_addr  = a;
        tick();
        ld_req_valid = 1'b0;
        chk("snap_take_first", 64'(snap_take), 64'(1));
        chk("vp_en_first", 64'(vp_en), 64'(1));
        chk("vp_addr_latched", 64'(vp_addr), 64'(a));
        chk("stall_snap", 64'(ov_stall), 64'(1));
        tick();
        chk("snap_take_second", 64'(snap_take), 64'(0));
        pred_valid = pv;
        pred_data  = pd;
        snap_done  = 1'b1;
        tick();
        pred_valid = 1'b0;
        snap_done  = 1'b0;
        chk("spec_valid_entry", 64'(spec_value_valid), 64'(pv));
        chk("active_entry", 64'(spec_active), 64'(1));
    endtask

    initial begin
        rst          = 1'b1;
        ld_req_valid = 1'b0;
        ld_req_addr  = '0;
        dc_valid     = 1'b0;
        dc_data      = '0;
        pred_valid   = 1'b0;
        pred_data    = '0;
        snap_done    = 1'b0;
        recover_done = 1'b0;
        tick();
        tick();
        chk("rst_active", 64'(spec_active), 64'(0));
        chk("rst_ncorrect", 64'(n_correct), 64'(0));
        chk("rst_nwrong", 64'(n_wrong), 64'(0));
        chk("rst_stall", 64'(ov_stall), 64'(0));
        chk("rst_vp_update", 64'(vp_update), 64'(0));
        rst = 1'b0;
        tick();

        // Same-cycle hit: train only, stay idle.
        ld_req_valid = 1'b1;
        ld_req_addr  = 32'h100;
        dc_valid     = 1'b1;
        dc_data      = 32'h1234;
        sb_q.push_back('{data: 32'h1234, addr: 32'h100});
        tick();
        ld_req_valid = 1'b0;
        dc_valid     = 1'b0;
        chk("hit_pulse", 64'(vp_update), 64'(1));
        chk("hit_idle", 64'(spec_active), 64'(0));
        chk("hit_cnt", 64'(n_correct), 64'(0));
        tick();
        chk("hit_pulse_end", 64'(vp_update), 64'(0));
        chk("hit_data_hold", 64'(vp_update_data), 64'(32'h1234));

        // Correct prediction, with a second load blocked during SPEC.
        start_spec(32'h200, 1'b1, 32'hAA);
        chk("spec_value", 64'(spec_value), 64'(32'hAA));
        chk("spec_no_stall", 64'(ov_stall), 64'(0));
        ld_req_valid = 1'b1;
        ld_req_addr  = 32'h204;
        #1;
        chk("spec_ld_stall", 64'(ov_stall), 64'(1));
        tick();
        ld_req_valid = 1'b0;
        chk("spec_no_snap", 64'(snap_take), 64'(0));
        chk("spec_still", 64'(spec_value_valid), 64'(1));
        chk("spec_addr_kept", 64'(vp_addr), 64'(32'h200));
        tick();
        tick();
        tick();
        dc_valid = 1'b1;
        dc_data  = 32'hAA;
        sb_q.push_back('{data: 32'hAA, addr: 32'h200});
        tick();
        dc_valid = 1'b0;
        chk("ok_ncorrect", 64'(n_correct), 64'(1));
        chk("ok_idle", 64'(spec_active), 64'(0));
        chk("ok_no_recover", 64'(recover_snapshot), 64'(0));
        chk("ok_no_flush", 64'(ov_flush), 64'(0));

        // Misprediction: recover held three cycles, then one flush cycle.
        start_spec(32'h300, 1'b1, 32'hAA);
        dc_valid = 1'b1;
        dc_data  = 32'hBB;
        sb_q.push_back('{data: 32'hBB, addr: 32'h300});
        tick();
        dc_valid = 1'b0;
        chk("mis_nwrong", 64'(n_wrong), 64'(1));
        chk("mis_ncorrect", 64'(n_correct), 64'(1));
        chk("mis_recover1", 64'(recover_snapshot), 64'(1));
        chk("mis_stall", 64'(ov_stall), 64'(1));
        chk("mis_spec_off", 64'(spec_value_valid), 64'(0));
        tick();
        chk("mis_recover2", 64'(recover_snapshot), 64'(1));
        tick();
        chk("mis_recover3", 64'(recover_snapshot), 64'(1));
        recover_done = 1'b1;
        tick();
        recover_done = 1'b0;
        chk("mis_flush", 64'(ov_flush), 64'(1));
        chk("mis_flush_stall", 64'(ov_stall), 64'(1));
        chk("mis_recover_off", 64'(recover_snapshot), 64'(0));
        tick();
        chk("mis_flush_once", 64'(ov_flush), 64'(0));
        chk("mis_idle", 64'(spec_active), 64'(0));

        // Timeout: RECOVER entered MSC cycles after SPEC entry.
        start_spec(32'h400, 1'b1, 32'h55);
        for (int i = 1; i < MSC; i++) begin
            tick();
            chk("to_still_spec", 64'(spec_value_valid), 64'(1));
        end
        tick();
        chk("to_recover", 64'(recover_snapshot), 64'(1));
        chk("to_nwrong", 64'(n_wrong), 64'(2));
        chk("to_no_update", 64'(vp_update), 64'(0));
        recover_done = 1'b1;
        tick();
        recover_done = 1'b0;
        chk("to_flush", 64'(ov_flush), 64'(1));
        tick();
        chk("to_idle", 64'(spec_active), 64'(0));

        // No confident prediction: NOSPEC, plain training on return.
        start_spec(32'h500, 1'b0, 32'h0);
        chk("nospec_no_stall", 64'(ov_stall), 64'(0));
        tick();
        chk("nospec_active", 64'(spec_active), 64'(1));
        dc_valid = 1'b1;
        dc_data  = 32'h77;
        sb_q.push_back('{data: 32'h77, addr: 32'h500});
        tick();
        dc_valid = 1'b0;
        chk("nospec_idle", 64'(spec_active), 64'(0));
        chk("nospec_counts", 64'({n_correct, n_wrong}), 64'({4'd1, 4'd2}));

        // Data and snap_done both arrive in the first SNAP cycle.
        ld_req_valid = 1'b1;
        ld_req_addr  = 32'h600;
        tick();
        ld_req_valid = 1'b0;
        dc_valid     = 1'b1;
        dc_data      = 32'h99;
        snap_done    = 1'b1;
        sb_q.push_back('{data: 32'h99, addr: 32'h600});
        tick();
        dc_valid   = 1'b0;
        snap_done  = 1'b0;
        chk("early_done_held", 64'(spec_active), 64'(1));
        chk("early_no_pulse", 64'(vp_update), 64'(0));
        pred_valid = 1'b1;
        pred_data  = 32'h11;
        tick();
        pred_valid = 1'b0;
        chk("act_seen_idle", 64'(spec_active), 64'(0));
        chk("act_seen_pulse", 64'(vp_update), 64'(1));
        chk("act_seen_counts", 64'({n_correct, n_wrong}), 64'({4'd1, 4'd2}));

        // Reset while recovering.
        start_spec(32'h700, 1'b1, 32'h1);
        dc_valid = 1'b1;
        dc_data  = 32'h2;
        sb_q.push_back('{data: 32'h2, addr: 32'h700});
        tick();
        dc_valid = 1'b0;
        chk("rr_recover", 64'(recover_snapshot), 64'(1));
        rst = 1'b1;
        #1;
        chk("rr_recover_drop", 64'(recover_snapshot), 64'(0));
        chk("rr_stall_drop", 64'(ov_stall), 64'(0));
        tick();
        chk("rr_idle", 64'(spec_active), 64'(0));
        chk("rr_counts", 64'({n_correct, n_wrong}), 64'(0));
        chk("rr_addr", 64'(vp_addr), 64'(0));
        chk("rr_upd_data", 64'(vp_update_data), 64'(0));
        chk("rr_update", 64'(vp_update), 64'(0));
        rst = 1'b0;
        tick();

        // Saturation of n_correct at all-ones.
        for (int i = 0; i < 17; i++) begin
            start_spec(32'h1000 + 32'(i), 1'b1, 32'hC0 + 32'(i));
            dc_valid = 1'b1;
            dc_data  = 32'hC0 + 32'(i);
            sb_q.push_back('{data: 32'hC0 + 32'(i), addr: 32'h1000 + 32'(i)});
            tick();
            dc_valid = 1'b0;
            chk("sat_ncorrect", 64'(n_correct), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        chk("sat_nwrong", 64'(n_wrong), 64'(0));

        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
